// File: rtl/ram_array_2r1w_pkg.sv
// Shared constants, clear-engine state encoding and width helper for the
// two-read/one-write RAM array.
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Ceiling log2, never less than 1 so a one-word array still gets a counter bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_array_2r1w_clear_fsm.sv
// Clear engine: walks every word address once, asserting a write strobe,
// started by a CLR pulse or automatically on the first edge after reset.
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             START_AUTO,
    output logic             BUSY,
    output logic             CLR_WE,
    output logic [CNT_W-1:0] CLR_ADDR
);

    localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

    clr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             auto_q, auto_d;

    // auto_q is only high until the first edge after reset release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (CLR || (START_AUTO && auto_q)) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            auto_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
        end
    end

    assign BUSY     = (state_q == CLEAR);
    assign CLR_WE   = (state_q == CLEAR);
    assign CLR_ADDR = cnt_q;

endmodule

// File: rtl/ram_array_2r1w.sv
// Parametrised RAM array with one write port, two synchronous read ports,
// optional output register, selectable read-during-write and a clear engine.
module ram_array_2r1w
    import ram_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 8,
    parameter int                DEPTH        = 256,
    parameter int                OUT_REG      = 0,
    parameter int                RDW_MODE     = 0,
    parameter int                CLR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLR_VAL      = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CLR,
    output logic              BUSY,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              RE1,
    input  logic [ADDR_W-1:0] RADDR1,
    output logic [DATA_W-1:0] DATA_OUT1,
    output logic              VALID1,
    input  logic              RE2,
    input  logic [ADDR_W-1:0] RADDR2,
    output logic [DATA_W-1:0] DATA_OUT2,
    output logic              VALID2
);

    localparam int              IDX_W     = clog2(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic              busy;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_addr;
    logic              user_we;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              re_in    [2];
    logic [ADDR_W-1:0] raddr_in [2];
    logic [DATA_W-1:0] dout     [2];
    logic              vout     [2];

    ram_clear_fsm #(
        .DEPTH (DEPTH),
        .CNT_W (IDX_W)
    ) u_clear_fsm (
        .CLK        (CLK),
        .RST        (RST),
        .CLR        (CLR),
        .START_AUTO (CLR_ON_RESET != 0),
        .BUSY       (busy),
        .CLR_WE     (clr_we),
        .CLR_ADDR   (clr_addr)
    );

    // A clear request in the same cycle pre-empts any user write.
    always_comb begin
        user_we   = WE && !busy && !CLR && ({1'b0, ADDR} < DEPTH_EXT);
        mem_we    = clr_we || user_we;
        mem_waddr = clr_we ? clr_addr : ADDR[IDX_W-1:0];
        mem_wdata = clr_we ? CLR_VAL : DATA_IN;
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign re_in[0]    = RE1;
    assign re_in[1]    = RE2;
    assign raddr_in[0] = RADDR1;
    assign raddr_in[1] = RADDR2;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic              rd_en;
        logic              in_range;
        logic              bypass;
        logic [DATA_W-1:0] s1_data_d, s1_data_q;
        logic              s1_valid_d, s1_valid_q;

        always_comb begin
            rd_en      = re_in[p] && !busy;
            in_range   = ({1'b0, raddr_in[p]} < DEPTH_EXT);
            bypass     = (RDW_MODE == RDW_WRITE_FIRST) && user_we && (ADDR == raddr_in[p]);
            s1_valid_d = rd_en;
            s1_data_d  = s1_data_q;
            if (rd_en) begin
                if (!in_range) begin
                    s1_data_d = '0;
                end else if (bypass) begin
                    s1_data_d = DATA_IN;
                end else begin
                    s1_data_d = mem[raddr_in[p][IDX_W-1:0]];
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
            end else begin
                s1_data_q  <= s1_data_d;
                s1_valid_q <= s1_valid_d;
            end
        end

        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] s2_data_d, s2_data_q;
            logic              s2_valid_q;

            always_comb begin
                s2_data_d = s1_valid_q ? s1_data_q : s2_data_q;
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_data_q  <= s2_data_d;
                    s2_valid_q <= s1_valid_q;
                end
            end

            assign dout[p] = s2_data_q;
            assign vout[p] = s2_valid_q;
        end else begin : g_no_out_reg
            assign dout[p] = s1_data_q;
            assign vout[p] = s1_valid_q;
        end
    end

    assign BUSY      = busy;
    assign DATA_OUT1 = dout[0];
    assign VALID1    = vout[0];
    assign DATA_OUT2 = dout[1];
    assign VALID2    = vout[1];

endmodule

// File: tb/tb_ram_array_2r1w.sv
// Directed bench: DUT A uses default parameters, DUT B uses DEPTH=200,
// OUT_REG=1, RDW_MODE=1; both share the same stimulus.
module tb_ram_array_2r1w;

    logic       clk = 1'b0;
    logic       rst, clr, we, re1, re2;
    logic [7:0] addr, dataIn, raddr1, raddr2;

    logic       busyA, valid1A, valid2A, busyB, valid1B, valid2B;
    logic [7:0] dout1A, dout2A, dout1B, dout2B;

    logic [7:0] sA1, sA2, sB1, sB2;
    logic       vA1, vA2, vB1, vB2;
    int         nA, nB, hits;
    int         errors = 0;
    int         checks = 0;

    ram_array_2r1w u_dut_a (
        .CLK(clk), .RST(rst), .CLR(clr), .BUSY(busyA),
        .WE(we), .ADDR(addr), .DATA_IN(dataIn),
        .RE1(re1), .RADDR1(raddr1), .DATA_OUT1(dout1A), .VALID1(valid1A),
        .RE2(re2), .RADDR2(raddr2), .DATA_OUT2(dout2A), .VALID2(valid2A)
    );

    ram_array_2r1w #(
        .DEPTH(200), .OUT_REG(1), .RDW_MODE(1)
    ) u_dut_b (
        .CLK(clk), .RST(rst), .CLR(clr), .BUSY(busyB),
        .WE(we), .ADDR(addr), .DATA_IN(dataIn),
        .RE1(re1), .RADDR1(raddr1), .DATA_OUT1(dout1B), .VALID1(valid1B),
        .RE2(re2), .RADDR2(raddr2), .DATA_OUT2(dout2B), .VALID2(valid2B)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [7:0] a, input logic [7:0] d,
                                 input logic r1, input logic [7:0] a1, input logic r2, input logic [7:0] a2);
        clr    = c;
        we     = w;
        addr   = a;
        dataIn = d;
        re1    = r1;
        raddr1 = a1;
        re2    = r2;
        raddr2 = a2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Port A results are one edge after RE, port B results two edges after RE.
    task automatic readPair(input logic [7:0] a1, input logic [7:0] a2);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, a1, 1'b1, a2);
        tick();
        sA1 = dout1A; vA1 = valid1A; sA2 = dout2A; vA2 = valid2A;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        sB1 = dout1B; vB1 = valid1B; sB2 = dout2B; vB2 = valid2B;
    endtask

    // First edge uses whatever the caller drove; later edges keep RE1 on to probe VALID.
    task automatic runClear(input int pulseAt);
        nA = 0; nB = 0; hits = 0;
        for (int i = 0; i < 400; i++) begin
            if (i > 0) begin
                applyStimulus(i == pulseAt, i == pulseAt, 8'h06, 8'h42, 1'b1, 8'h05, 1'b0, 8'h00);
            end
            tick();
            if (busyA) nA++;
            if (busyB) nB++;
            if ((busyA && valid1A) || (busyB && valid1B)) hits++;
            if (!busyA && !busyB) break;
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) tick();
        checkOutput("rst_busyA", busyA, 1'b0);
        checkOutput("rst_valid1A", valid1A, 1'b0);
        checkOutput("rst_dout1A", dout1A, 8'h00);
        checkOutput("rst_busyB", busyB, 1'b0);
        checkOutput("rst_dout2B", dout2B, 8'h00);

        rst = 1'b0;
        checkOutput("release_busyA", busyA, 1'b0);
        runClear(-1);
        checkOutput("auto_clear_cyclesA", nA, 256);
        checkOutput("auto_clear_cyclesB", nB, 200);
        checkOutput("auto_clear_valid", hits, 0);
        readPair(8'h00, 8'h7F);
        checkOutput("t1_dout1A_00", sA1, 8'h00);
        checkOutput("t1_valid1A_00", vA1, 1'b1);
        checkOutput("t1_dout2A_7F", sA2, 8'h00);
        checkOutput("t1_valid1B_00", vB1, 1'b1);
        readPair(8'hFF, 8'h00);
        checkOutput("t1_dout1A_FF", sA1, 8'h00);
        checkOutput("t1_valid1A_FF", vA1, 1'b1);
        checkOutput("t1_dout1B_FF_oor", sB1, 8'h00);
        checkOutput("t1_valid1B_FF_oor", vB1, 1'b1);

        applyStimulus(1'b0, 1'b1, 8'h10, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b1, 8'h20);
        tick();
        checkOutput("t2_dout1A", dout1A, 8'hFF);
        checkOutput("t2_valid1A", valid1A, 1'b1);
        checkOutput("t2_dout2A", dout2A, 8'h00);
        checkOutput("t2_valid2A", valid2A, 1'b1);
        checkOutput("t2_valid1B_early", valid1B, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        checkOutput("t2_valid1A_idle", valid1A, 1'b0);
        checkOutput("t2_dout1A_hold", dout1A, 8'hFF);
        checkOutput("t2_dout1B", dout1B, 8'hFF);
        checkOutput("t2_valid1B", valid1B, 1'b1);
        checkOutput("t2_dout2B", dout2B, 8'h00);
        checkOutput("t2_valid2B", valid2B, 1'b1);
        tick();
        checkOutput("t2_valid1B_idle", valid1B, 1'b0);

        applyStimulus(1'b0, 1'b1, 8'h10, 8'hAA, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b1, 8'h10, 8'h55, 1'b1, 8'h10, 1'b0, 8'h00);
        tick();
        checkOutput("t3_read_first_A", dout1A, 8'hAA);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b0, 8'h00);
        tick();
        checkOutput("t3_next_read_A", dout1A, 8'h55);
        checkOutput("t3_write_first_B", dout1B, 8'h55);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        checkOutput("t3_next_read_B", dout1B, 8'h55);
        checkOutput("t3_next_valid_B", valid1B, 1'b1);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 8'h3C, 1'b0, 8'h00, 1'b0, 8'h00);
            tick();
        end
        readPair(8'h05, 8'h0F);
        checkOutput("t4_fill_05_A", sA1, 8'h3C);
        checkOutput("t4_fill_0F_B", sB2, 8'h3C);
        applyStimulus(1'b1, 1'b1, 8'h05, 8'h99, 1'b0, 8'h00, 1'b0, 8'h00);
        runClear(100);
        checkOutput("t4_clear_cyclesA", nA, 256);
        checkOutput("t4_clear_cyclesB", nB, 200);
        checkOutput("t4_valid_during_clear", hits, 0);
        readPair(8'h05, 8'h06);
        checkOutput("t4_dropped_05_A", sA1, 8'h00);
        checkOutput("t4_dropped_06_A", sA2, 8'h00);
        checkOutput("t4_dropped_05_B", sB1, 8'h00);
        readPair(8'h0F, 8'h00);
        checkOutput("t4_cleared_0F_A", sA1, 8'h00);
        checkOutput("t4_cleared_0F_B", sB1, 8'h00);

        applyStimulus(1'b0, 1'b1, 8'hC8, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        readPair(8'hC7, 8'hC8);
        checkOutput("t5_C7_A", sA1, 8'h00);
        checkOutput("t5_C8_A", sA2, 8'h77);
        checkOutput("t5_C7_B", sB1, 8'h00);
        checkOutput("t5_C8_B_oor", sB2, 8'h00);
        checkOutput("t5_C8_B_valid", vB2, 1'b1);

        applyStimulus(1'b0, 1'b1, 8'h30, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        readPair(8'h30, 8'h30);
        checkOutput("t6_pre_A", sA1, 8'h5A);
        checkOutput("t6_pre_B", sB2, 8'h5A);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h30, 1'b0, 8'h00);
        repeat (49) tick();
        checkOutput("t6_mid_busyA", busyA, 1'b1);
        checkOutput("t6_mid_hold_A", dout1A, 8'h5A);
        checkOutput("t6_mid_valid_A", valid1A, 1'b0);
        checkOutput("t6_mid_hold_B", dout1B, 8'h5A);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_busyA", busyA, 1'b0);
        checkOutput("t6_rst_dout1A", dout1A, 8'h00);
        checkOutput("t6_rst_dout2A", dout2A, 8'h00);
        checkOutput("t6_rst_dout1B", dout1B, 8'h00);
        checkOutput("t6_rst_busyB", busyB, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        tick();
        checkOutput("t6_rst_hold_busyA", busyA, 1'b0);
        rst = 1'b0;
        runClear(-1);
        checkOutput("t6_restart_cyclesA", nA, 256);
        checkOutput("t6_restart_cyclesB", nB, 200);
        readPair(8'h30, 8'h00);
        checkOutput("t6_after_A", sA1, 8'h00);
        checkOutput("t6_after_B", sB1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
